// File: rtl/rob_tag_ctrl.sv
// ---------------------------------------------------------------------------
// rob_tag_ctrl
// Reorder-buffer tag controller. Allocates tags in program order from a
// circular buffer, marks entries done from two result-broadcast ports, retires
// up to two finished entries per cycle strictly in order, and tells the
// register alias table which registers to allocate and which to release.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   disp_valid/has_dest/dest   dispatch request and destination register
//   disp_ready, disp_tag       dispatch handshake and tag granted (tail)
//   cdb_valid/tag, cdb_valid2/tag2   two completion broadcast ports
//   flush                      discard every in-flight entry
//   rat_write/dest/tag         RAT allocate port (same cycle as dispatch)
//   rat_free/free_reg, rat_free2/free_reg2   RAT release ports per retire slot
//   commit_cnt                 entries retired this cycle (0..2)
//   count, full, empty         occupancy
// ---------------------------------------------------------------------------
module rob_tag_ctrl #(
   parameter int DEPTH = 32,
   parameter int NREG  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      disp_valid,
   input  logic                      disp_has_dest,
   input  logic [$clog2(NREG)-1:0]   disp_dest,
   output logic                      disp_ready,
   output logic [$clog2(DEPTH)-1:0]  disp_tag,
   input  logic                      cdb_valid,
   input  logic [$clog2(DEPTH)-1:0]  cdb_tag,
   input  logic                      cdb_valid2,
   input  logic [$clog2(DEPTH)-1:0]  cdb_tag2,
   input  logic                      flush,
   output logic                      rat_write,
   output logic [$clog2(NREG)-1:0]   rat_dest,
   output logic [$clog2(DEPTH)-1:0]  rat_tag,
   output logic                      rat_free,
   output logic [$clog2(NREG)-1:0]   rat_free_reg,
   output logic                      rat_free2,
   output logic [$clog2(NREG)-1:0]   rat_free_reg2,
   output logic [1:0]                commit_cnt,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);

   localparam int TAG_W = $clog2(DEPTH);
   localparam int REG_W = $clog2(NREG);
   localparam logic [TAG_W:0]   FULL_CNT = (TAG_W + 1)'(DEPTH);
   localparam logic [TAG_W:0]   ZERO_CNT = {(TAG_W + 1){1'b0}};
   localparam logic [TAG_W-1:0] TAG_ONE  = {{(TAG_W - 1){1'b0}}, 1'b1};
   localparam logic [TAG_W-1:0] TAG_ZERO = {TAG_W{1'b0}};

   // Entry storage
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] done_q, done_d;
   logic [DEPTH-1:0] has_dest_q, has_dest_d;
   logic [REG_W-1:0] dest_q [DEPTH];
   logic [REG_W-1:0] dest_d [DEPTH];

   // Pointers and occupancy
   logic [TAG_W-1:0] head_q, head_d;
   logic [TAG_W-1:0] tail_q, tail_d;
   logic [TAG_W:0]   count_q, count_d;

   // Youngest in-flight producer of each architectural register
   logic [TAG_W-1:0] last_tag_q [NREG];
   logic [TAG_W-1:0] last_tag_d [NREG];
   logic [NREG-1:0]  last_vld_q, last_vld_d;

   // Combinational decode of the current state
   logic             full_s;
   logic             empty_s;
   logic             accept_s;
   logic             alloc_s;
   logic [TAG_W-1:0] head_p1_s;
   logic             commit0_s;
   logic             commit1_s;
   logic [REG_W-1:0] dest0_s;
   logic [REG_W-1:0] dest1_s;
   logic             free0_s;
   logic             free1_s;
   logic [1:0]       commit_cnt_s;

   // Handshake, retire and release decisions for the current cycle
   always_comb begin
      full_s     = (count_q == FULL_CNT);
      empty_s    = (count_q == ZERO_CNT);
      disp_ready = !full_s && !flush;
      // A dispatch seen while reset is held must not reach the RAT.
      accept_s   = disp_valid && disp_ready && !rst;
      alloc_s    = accept_s && disp_has_dest;
      head_p1_s  = head_q + TAG_ONE;

      // Done bits are registered, so a completion seen this cycle can only
      // retire from the next cycle on.
      commit0_s  = !flush && valid_q[head_q] && done_q[head_q];
      commit1_s  = commit0_s && valid_q[head_p1_s] && done_q[head_p1_s];
      dest0_s    = dest_q[head_q];
      dest1_s    = dest_q[head_p1_s];

      // Release a register only if the retiring entry is still its youngest
      // producer and a dispatch this cycle is not re-mapping the same register.
      free0_s    = commit0_s && has_dest_q[head_q] && last_vld_q[dest0_s] &&
                   (last_tag_q[dest0_s] == head_q) &&
                   !(alloc_s && (disp_dest == dest0_s));
      free1_s    = commit1_s && has_dest_q[head_p1_s] && last_vld_q[dest1_s] &&
                   (last_tag_q[dest1_s] == head_p1_s) &&
                   !(alloc_s && (disp_dest == dest1_s));

      if (commit1_s) begin
         commit_cnt_s = 2'd2;
      end else if (commit0_s) begin
         commit_cnt_s = 2'd1;
      end else begin
         commit_cnt_s = 2'd0;
      end
   end

   // Next-state computation: completion, then retire, then dispatch
   always_comb begin
      valid_d    = valid_q;
      done_d     = done_q;
      has_dest_d = has_dest_q;
      dest_d     = dest_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      last_tag_d = last_tag_q;
      last_vld_d = last_vld_q;

      if (flush) begin
         valid_d    = {DEPTH{1'b0}};
         done_d     = {DEPTH{1'b0}};
         last_vld_d = {NREG{1'b0}};
         head_d     = TAG_ZERO;
         tail_d     = TAG_ZERO;
         count_d    = ZERO_CNT;
      end else begin
         // Completions only land on live entries; both ports may name one tag.
         done_d[cdb_tag]  = done_d[cdb_tag]  | (cdb_valid  & valid_q[cdb_tag]);
         done_d[cdb_tag2] = done_d[cdb_tag2] | (cdb_valid2 & valid_q[cdb_tag2]);

         // Retire: clear the committed slots and drop released mappings.
         valid_d[head_q]    = valid_d[head_q]    & ~commit0_s;
         done_d[head_q]     = done_d[head_q]     & ~commit0_s;
         valid_d[head_p1_s] = valid_d[head_p1_s] & ~commit1_s;
         done_d[head_p1_s]  = done_d[head_p1_s]  & ~commit1_s;
         last_vld_d[dest0_s] = last_vld_d[dest0_s] & ~free0_s;
         last_vld_d[dest1_s] = last_vld_d[dest1_s] & ~free1_s;

         // Dispatch: the tail slot is never a retiring slot, so no overlap.
         valid_d[tail_q]    = valid_d[tail_q] | accept_s;
         done_d[tail_q]     = done_d[tail_q] & ~accept_s;
         has_dest_d[tail_q] = accept_s ? disp_has_dest : has_dest_d[tail_q];
         dest_d[tail_q]     = accept_s ? disp_dest : dest_d[tail_q];
         last_tag_d[disp_dest] = alloc_s ? tail_q : last_tag_d[disp_dest];
         last_vld_d[disp_dest] = last_vld_d[disp_dest] | alloc_s;

         tail_d  = tail_q + {{(TAG_W - 1){1'b0}}, accept_s};
         head_d  = head_q + {{(TAG_W - 2){1'b0}}, commit_cnt_s};
         count_d = count_q + {{TAG_W{1'b0}}, accept_s}
                           - {{(TAG_W - 1){1'b0}}, commit_cnt_s};
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= {DEPTH{1'b0}};
         done_q     <= {DEPTH{1'b0}};
         has_dest_q <= {DEPTH{1'b0}};
         head_q     <= TAG_ZERO;
         tail_q     <= TAG_ZERO;
         count_q    <= ZERO_CNT;
         last_vld_q <= {NREG{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= {REG_W{1'b0}};
         end
         for (int i = 0; i < NREG; i++) begin
            last_tag_q[i] <= TAG_ZERO;
         end
      end else begin
         valid_q    <= valid_d;
         done_q     <= done_d;
         has_dest_q <= has_dest_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         last_vld_q <= last_vld_d;
         dest_q     <= dest_d;
         last_tag_q <= last_tag_d;
      end
   end

   // Output mapping
   always_comb begin
      disp_tag      = tail_q;
      rat_write     = alloc_s;
      rat_dest      = disp_dest;
      rat_tag       = tail_q;
      rat_free      = free0_s;
      rat_free_reg  = dest0_s;
      rat_free2     = free1_s;
      rat_free_reg2 = dest1_s;
      commit_cnt    = commit_cnt_s;
      count         = count_q;
      full          = full_s;
      empty         = empty_s;
   end

endmodule

// File: tb/tb_rob_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rob_tag_ctrl
// Self-checking bench for rob_tag_ctrl. A reference model keeps the in-flight
// instructions as an ordered queue plus a per-register "youngest producer"
// map; every cycle its predictions are compared against the DUT. A table of
// hand-derived vectors, a few directed sequences (full/wrap, flush, reset in
// flight) and a long random run are all driven through the same step task.
// ---------------------------------------------------------------------------
module tb_rob_tag_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       disp_valid, disp_has_dest;
   logic [4:0] disp_dest;
   logic       disp_ready;
   logic [4:0] disp_tag;
   logic       cdb_valid, cdb_valid2;
   logic [4:0] cdb_tag, cdb_tag2;
   logic       flush;
   logic       rat_write;
   logic [4:0] rat_dest, rat_tag;
   logic       rat_free, rat_free2;
   logic [4:0] rat_free_reg, rat_free_reg2;
   logic [1:0] commit_cnt;
   logic [5:0] count;
   logic       full, empty;

   always #5 clk = ~clk;

   rob_tag_ctrl #(.DEPTH(32), .NREG(32)) dut (
      .clk(clk), .rst(rst),
      .disp_valid(disp_valid), .disp_has_dest(disp_has_dest), .disp_dest(disp_dest),
      .disp_ready(disp_ready), .disp_tag(disp_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_valid2(cdb_valid2), .cdb_tag2(cdb_tag2),
      .flush(flush),
      .rat_write(rat_write), .rat_dest(rat_dest), .rat_tag(rat_tag),
      .rat_free(rat_free), .rat_free_reg(rat_free_reg),
      .rat_free2(rat_free2), .rat_free_reg2(rat_free_reg2),
      .commit_cnt(commit_cnt), .count(count), .full(full), .empty(empty)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: program-ordered in-flight list and register map
   typedef struct {
      int tag;
      bit hd;
      int dest;
      bit done;
   } ent_t;
   ent_t q[$];
   int   m_tail;
   bit   m_lvld [32];
   int   m_ltag [32];

   // Outputs captured by the most recent step
   int a_ready, a_tag, a_rw, a_cc, a_f1, a_fr1, a_f2, a_fr2, a_cnt, a_full, a_empty;

   typedef struct {
      bit dv; bit dhd; int dd;
      bit c1v; int c1t; bit c2v; int c2t; bit fl;
      int e_ready; int e_tag; int e_rw; int e_cc;
      int e_f1; int e_fr1; int e_f2; int e_fr2; int e_cnt;
   } vec_t;
   vec_t tv [34];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_tail = 0;
      for (int i = 0; i < 32; i++) begin
         m_lvld[i] = 1'b0;
         m_ltag[i] = 0;
      end
   endtask

   // One clock cycle: drive, check against the model, clock, update the model.
   // Entered and left 1 time unit after a rising edge.
   task automatic step(input bit dv, input bit dhd, input int dd,
                       input bit c1v, input int c1t, input bit c2v, input int c2t,
                       input bit fl);
      int   e_ready, e_rw, n_com;
      bit   acc;
      bit   fr [2];
      ent_t e;
      disp_valid = dv;  disp_has_dest = dhd; disp_dest = 5'(dd);
      cdb_valid  = c1v; cdb_tag  = 5'(c1t);
      cdb_valid2 = c2v; cdb_tag2 = 5'(c2t);
      flush      = fl;
      #3;
      e_ready = (q.size() < 32 && !fl) ? 1 : 0;
      acc     = dv && (e_ready == 1);
      e_rw    = (acc && dhd) ? 1 : 0;
      n_com   = 0;
      if (!fl && q.size() >= 1) begin
         if (q[0].done) n_com = 1;
      end
      if (n_com == 1 && q.size() >= 2) begin
         if (q[1].done) n_com = 2;
      end
      for (int k = 0; k < 2; k++) begin
         fr[k] = 1'b0;
         if (k < n_com) begin
            e = q[k];
            fr[k] = e.hd && m_lvld[e.dest] && (m_ltag[e.dest] == e.tag) &&
                    !(e_rw == 1 && dd == e.dest);
         end
      end
      a_ready = int'(disp_ready); a_tag = int'(disp_tag); a_rw = int'(rat_write);
      a_cc = int'(commit_cnt); a_f1 = int'(rat_free); a_fr1 = int'(rat_free_reg);
      a_f2 = int'(rat_free2); a_fr2 = int'(rat_free_reg2); a_cnt = int'(count);
      a_full = int'(full); a_empty = int'(empty);

      chk("disp_ready", a_ready, e_ready);
      chk("disp_tag", a_tag, m_tail);
      chk("rat_write", a_rw, e_rw);
      if (e_rw == 1) begin
         chk("rat_dest", int'(rat_dest), dd);
         chk("rat_tag", int'(rat_tag), m_tail);
      end
      chk("commit_cnt", a_cc, n_com);
      chk("rat_free", a_f1, int'(fr[0]));
      chk("rat_free2", a_f2, int'(fr[1]));
      if (fr[0]) chk("rat_free_reg", a_fr1, q[0].dest);
      if (fr[1]) chk("rat_free_reg2", a_fr2, q[1].dest);
      chk("count", a_cnt, q.size());
      chk("full", a_full, (q.size() == 32) ? 1 : 0);
      chk("empty", a_empty, (q.size() == 0) ? 1 : 0);

      @(posedge clk);
      #1;
      if (fl) begin
         model_reset();
      end else begin
         for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            if ((c1v && e.tag == c1t) || (c2v && e.tag == c2t)) begin
               e.done = 1'b1;
               q[i] = e;
            end
         end
         for (int k = 0; k < 2; k++) begin
            if (fr[k]) m_lvld[q[k].dest] = 1'b0;
         end
         repeat (n_com) void'(q.pop_front());
         if (acc) begin
            e.tag = m_tail; e.hd = dhd; e.dest = dd; e.done = 1'b0;
            q.push_back(e);
            if (dhd) begin
               m_ltag[dd] = m_tail;
               m_lvld[dd] = 1'b1;
            end
            m_tail = (m_tail + 1) % 32;
         end
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Hold reset (with a dispatch request present) and check the reset outputs.
   task automatic do_reset();
      rst = 1'b1;
      disp_valid = 1'b1; disp_has_dest = 1'b1; disp_dest = 5'd5;
      cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_valid2 = 1'b0; cdb_tag2 = 5'd0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #4;
      chk("rst_disp_ready", int'(disp_ready), 1);
      chk("rst_disp_tag", int'(disp_tag), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_commit_cnt", int'(commit_cnt), 0);
      chk("rst_rat_write", int'(rat_write), 0);
      chk("rst_rat_free", int'(rat_free), 0);
      chk("rst_rat_free2", int'(rat_free2), 0);
      rst = 1'b0;
      disp_valid = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   initial begin
      // dv dhd dd c1v c1t c2v c2t fl | ready tag rw cc f1 fr1 f2 fr2 cnt
      tv[0]  = '{1,1,5,  0,0, 0,0, 0,  1,0, 1,0, 0,0, 0,0, 0};
      tv[1]  = '{0,0,0,  0,0, 0,0, 0,  1,1, 0,0, 0,0, 0,0, 1};
      tv[2]  = '{0,0,0,  1,0, 0,0, 0,  1,1, 0,0, 0,0, 0,0, 1};
      tv[3]  = '{0,0,0,  0,0, 0,0, 0,  1,1, 0,1, 1,5, 0,0, 1};
      tv[4]  = '{0,0,0,  0,0, 0,0, 0,  1,1, 0,0, 0,0, 0,0, 0};
      tv[5]  = '{1,1,3,  0,0, 0,0, 0,  1,1, 1,0, 0,0, 0,0, 0};
      tv[6]  = '{1,1,4,  0,0, 0,0, 0,  1,2, 1,0, 0,0, 0,0, 1};
      tv[7]  = '{0,0,0,  1,2, 0,0, 0,  1,3, 0,0, 0,0, 0,0, 2};
      tv[8]  = '{0,0,0,  0,0, 0,0, 0,  1,3, 0,0, 0,0, 0,0, 2};
      tv[9]  = '{0,0,0,  1,1, 0,0, 0,  1,3, 0,0, 0,0, 0,0, 2};
      tv[10] = '{0,0,0,  0,0, 0,0, 0,  1,3, 0,2, 1,3, 1,4, 2};
      tv[11] = '{0,0,0,  0,0, 0,0, 0,  1,3, 0,0, 0,0, 0,0, 0};
      tv[12] = '{1,1,7,  0,0, 0,0, 0,  1,3, 1,0, 0,0, 0,0, 0};
      tv[13] = '{1,1,7,  0,0, 0,0, 0,  1,4, 1,0, 0,0, 0,0, 1};
      tv[14] = '{0,0,0,  1,3, 0,0, 0,  1,5, 0,0, 0,0, 0,0, 2};
      tv[15] = '{0,0,0,  0,0, 0,0, 0,  1,5, 0,1, 0,0, 0,0, 2};
      tv[16] = '{0,0,0,  1,4, 0,0, 0,  1,5, 0,0, 0,0, 0,0, 1};
      tv[17] = '{0,0,0,  0,0, 0,0, 0,  1,5, 0,1, 1,7, 0,0, 1};
      tv[18] = '{0,0,0,  0,0, 0,0, 0,  1,5, 0,0, 0,0, 0,0, 0};
      tv[19] = '{1,1,9,  0,0, 0,0, 0,  1,5, 1,0, 0,0, 0,0, 0};
      tv[20] = '{0,0,0,  1,5, 0,0, 0,  1,6, 0,0, 0,0, 0,0, 1};
      tv[21] = '{1,1,9,  0,0, 0,0, 0,  1,6, 1,1, 0,0, 0,0, 1};
      tv[22] = '{0,0,0,  0,0, 0,0, 0,  1,7, 0,0, 0,0, 0,0, 1};
      tv[23] = '{0,0,0,  1,6, 0,0, 0,  1,7, 0,0, 0,0, 0,0, 1};
      tv[24] = '{0,0,0,  0,0, 0,0, 0,  1,7, 0,1, 1,9, 0,0, 1};
      tv[25] = '{0,0,0,  0,0, 0,0, 0,  1,7, 0,0, 0,0, 0,0, 0};
      tv[26] = '{1,0,12, 0,0, 0,0, 0,  1,7, 0,0, 0,0, 0,0, 0};
      tv[27] = '{1,1,12, 1,7, 1,7, 0,  1,8, 1,0, 0,0, 0,0, 1};
      tv[28] = '{0,0,0,  1,8, 0,0, 0,  1,9, 0,1, 0,0, 0,0, 2};
      tv[29] = '{0,0,0,  0,0, 0,0, 0,  1,9, 0,1, 1,12,0,0, 1};
      tv[30] = '{0,0,0,  1,20,0,0, 0,  1,9, 0,0, 0,0, 0,0, 0};
      tv[31] = '{1,1,1,  0,0, 0,0, 0,  1,9, 1,0, 0,0, 0,0, 0};
      tv[32] = '{0,0,0,  0,0, 0,0, 0,  1,10,0,0, 0,0, 0,0, 1};
      tv[33] = '{0,0,0,  0,0, 0,0, 0,  1,10,0,0, 0,0, 0,0, 1};

      rst = 1'b1;
      do_reset();

      // Table-driven vectors
      for (int i = 0; i < 34; i++) begin
         step(tv[i].dv, tv[i].dhd, tv[i].dd, tv[i].c1v, tv[i].c1t,
              tv[i].c2v, tv[i].c2t, tv[i].fl);
         chk($sformatf("row%0d_ready", i), a_ready, tv[i].e_ready);
         chk($sformatf("row%0d_tag", i), a_tag, tv[i].e_tag);
         chk($sformatf("row%0d_rw", i), a_rw, tv[i].e_rw);
         chk($sformatf("row%0d_cc", i), a_cc, tv[i].e_cc);
         chk($sformatf("row%0d_free", i), a_f1, tv[i].e_f1);
         chk($sformatf("row%0d_free2", i), a_f2, tv[i].e_f2);
         if (tv[i].e_f1 == 1) chk($sformatf("row%0d_free_reg", i), a_fr1, tv[i].e_fr1);
         if (tv[i].e_f2 == 1) chk($sformatf("row%0d_free_reg2", i), a_fr2, tv[i].e_fr2);
         chk($sformatf("row%0d_count", i), a_cnt, tv[i].e_cnt);
      end

      // Fill to full, then retire tag 0 and check the wrapped tail
      do_reset();
      for (int i = 0; i < 32; i++) step(1, 1, i, 0, 0, 0, 0, 0);
      step(1, 1, 3, 0, 0, 0, 0, 0);
      chk("full_flag", a_full, 1);
      chk("full_ready", a_ready, 0);
      chk("full_count", a_cnt, 32);
      chk("full_no_write", a_rw, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      chk("full_no_early_commit", a_cc, 0);
      idle();
      chk("full_commit", a_cc, 1);
      step(1, 1, 20, 0, 0, 0, 0, 0);
      chk("wrap_tag", a_tag, 0);
      chk("wrap_write", a_rw, 1);
      chk("wrap_count", a_cnt, 31);

      // Flush with 10 in flight and two committable entries
      do_reset();
      for (int i = 0; i < 10; i++) step(1, 1, i + 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 1, 1, 0);
      step(1, 1, 2, 1, 5, 0, 0, 1);
      chk("flush_cc", a_cc, 0);
      chk("flush_free", a_f1, 0);
      chk("flush_write", a_rw, 0);
      chk("flush_ready", a_ready, 0);
      chk("flush_count_before", a_cnt, 10);
      step(1, 1, 4, 1, 0, 0, 0, 0);
      chk("post_flush_count", a_cnt, 0);
      chk("post_flush_empty", a_empty, 1);
      chk("post_flush_tag", a_tag, 0);
      idle();
      chk("stale_cdb_ignored", a_cc, 0);
      idle();
      chk("stale_cdb_ignored2", a_cc, 0);

      // Reset asserted with committable entries in flight
      do_reset();
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 2, 0, 0, 0, 0, 0);
      step(1, 1, 3, 1, 0, 1, 1, 0);
      rst = 1'b1;
      disp_valid = 1'b1; disp_has_dest = 1'b1; disp_dest = 5'd6;
      #2;
      chk("midrst_cc", int'(commit_cnt), 0);
      chk("midrst_free", int'(rat_free), 0);
      chk("midrst_free2", int'(rat_free2), 0);
      chk("midrst_write", int'(rat_write), 0);
      chk("midrst_count", int'(count), 0);
      chk("midrst_empty", int'(empty), 1);
      chk("midrst_tag", int'(disp_tag), 0);
      do_reset();

      // Random traffic against the model
      for (int cyc = 0; cyc < 4000; cyc++) begin
         int   p_done, t1, t2, dd;
         bit   v1, v2, dv, dhd, fl;
         ent_t e;
         p_done = ((cyc / 500) % 2 == 0) ? 40 : 4;
         v1 = 1'b0; t1 = 0; v2 = 1'b0; t2 = 0;
         if (q.size() > 0 && $urandom_range(0, 99) < p_done) begin
            e = q[$urandom_range(0, q.size() - 1)];
            v1 = 1'b1; t1 = e.tag;
         end else if ($urandom_range(0, 99) < 5) begin
            v1 = 1'b1; t1 = $urandom_range(0, 31);
         end
         if (q.size() > 0 && $urandom_range(0, 99) < p_done) begin
            e = q[$urandom_range(0, q.size() - 1)];
            v2 = 1'b1; t2 = e.tag;
         end else if ($urandom_range(0, 99) < 5) begin
            v2 = 1'b1; t2 = $urandom_range(0, 31);
         end
         dv  = ($urandom_range(0, 99) < 65);
         dhd = ($urandom_range(0, 99) < 80);
         dd  = $urandom_range(0, 7);
         fl  = ($urandom_range(0, 299) == 0);
         step(dv, dhd, dd, v1, t1, v2, t2, fl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
